// File: rtl/mod_step_counter.sv
// Modulo-M up/down counter with programmable step, synchronous load and
// wrap / saturate / one-shot terminal behaviour; ovf/unf pulses allow cascading.
module mod_step_counter #(
    parameter int M      = 13,
    parameter int B      = $clog2(M),
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              inc,
    input  logic              dec,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        mode,
    input  logic              load,
    input  logic [B-1:0]      load_val,
    output logic [B-1:0]      cnt,
    output logic              ovf,
    output logic              unf,
    output logic              done,
    output logic              at_max,
    output logic              at_zero
);

    localparam int unsigned MAXI = M - 1;
    localparam int unsigned MODI = M;
    localparam int W = (STEP_W > B + 1) ? STEP_W : B + 1;
    localparam logic [B:0]   MAXV = MAXI[B:0];
    localparam logic [B:0]   MODV = MODI[B:0];
    localparam logic [W-1:0] MAXW = MAXI[W-1:0];

    localparam logic [1:0] MODE_SAT = 2'b01;
    localparam logic [1:0] MODE_OS  = 2'b10;

    function automatic logic [B:0] clamp_max(input logic [B:0] v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    logic [W-1:0] step_w;
    logic [B:0]   se;
    logic [B:0]   c, up_sum, up_wrap, dn_diff, dn_wrap;
    logic [B-1:0] cnt_nxt;
    logic         ovf_nxt, unf_nxt, done_nxt;

    assign step_w  = W'(step);
    assign se      = (step_w > MAXW) ? MAXV : step_w[B:0];

    // All arithmetic is one bit wider than cnt so sums of two in-range values never overflow.
    assign c       = {1'b0, cnt};
    assign up_sum  = c + se;
    assign up_wrap = up_sum - MODV;
    assign dn_diff = c - se;
    assign dn_wrap = c + MODV - se;

    always_comb begin
        cnt_nxt  = cnt;
        done_nxt = done;
        ovf_nxt  = 1'b0;
        unf_nxt  = 1'b0;
        if (load) begin
            cnt_nxt  = B'(clamp_max({1'b0, load_val}));
            done_nxt = 1'b0;
        end else if (en) begin
            if (done && mode != MODE_OS)
                done_nxt = 1'b0;
            if (inc != dec && se != '0 && !(done && mode == MODE_OS)) begin
                case (mode)
                    MODE_SAT: begin
                        if (inc) begin
                            if (up_sum > MAXV) begin
                                cnt_nxt = B'(MAXV);
                                ovf_nxt = 1'b1;
                            end else begin
                                cnt_nxt = B'(up_sum);
                            end
                        end else begin
                            if (c < se) begin
                                cnt_nxt = '0;
                                unf_nxt = 1'b1;
                            end else begin
                                cnt_nxt = B'(dn_diff);
                            end
                        end
                    end
                    MODE_OS: begin
                        if (inc) begin
                            if (up_sum >= MAXV) begin
                                cnt_nxt  = B'(MAXV);
                                done_nxt = 1'b1;
                                ovf_nxt  = 1'b1;
                            end else begin
                                cnt_nxt = B'(up_sum);
                            end
                        end else begin
                            if (c <= se) begin
                                cnt_nxt  = '0;
                                done_nxt = 1'b1;
                                unf_nxt  = 1'b1;
                            end else begin
                                cnt_nxt = B'(dn_diff);
                            end
                        end
                    end
                    default: begin
                        // Wrap, also used for the reserved mode encoding.
                        if (inc) begin
                            if (up_sum <= MAXV) begin
                                cnt_nxt = B'(up_sum);
                            end else begin
                                cnt_nxt = B'(up_wrap);
                                ovf_nxt = 1'b1;
                            end
                        end else begin
                            if (c >= se) begin
                                cnt_nxt = B'(dn_diff);
                            end else begin
                                cnt_nxt = B'(dn_wrap);
                                unf_nxt = 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
            done <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            ovf  <= ovf_nxt;
            unf  <= unf_nxt;
            done <= done_nxt;
        end
    end

    assign at_max  = (cnt == B'(MAXV));
    assign at_zero = (cnt == '0);

endmodule

// File: tb/tb_mod_step_counter.sv
// Directed table-driven bench for mod_step_counter at M=13 (4-bit count, 4-bit step).
module tb_mod_step_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, inc, dec, load;
    logic [3:0] step;
    logic [1:0] mode;
    logic [3:0] load_val;
    logic [3:0] cnt;
    logic       ovf, unf, done, at_max, at_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic       en;
        logic       inc;
        logic       dec;
        logic [3:0] step;
        logic [1:0] mode;
        int         ecnt;
        int         eovf;
        int         eunf;
        int         edone;
    } vec_t;

    vec_t vecs[$];

    mod_step_counter #(.M(13), .B(4), .STEP_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec), .step(step),
        .mode(mode), .load(load), .load_val(load_val), .cnt(cnt), .ovf(ovf),
        .unf(unf), .done(done), .at_max(at_max), .at_zero(at_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic ld, input int lv, input logic e, input logic i,
                       input logic d, input int s, input int m, input int ecnt,
                       input int eovf, input int eunf, input int edone);
        vec_t v;
        v.ld = ld; v.lv = 4'(lv); v.en = e; v.inc = i; v.dec = d;
        v.step = 4'(s); v.mode = 2'(m);
        v.ecnt = ecnt; v.eovf = eovf; v.eunf = eunf; v.edone = edone;
        vecs.push_back(v);
    endtask

    task automatic chk_all(input string tag, input int ecnt, input int eovf,
                           input int eunf, input int edone);
        chk({tag, " cnt"}, int'(cnt), ecnt);
        chk({tag, " ovf"}, int'(ovf), eovf);
        chk({tag, " unf"}, int'(unf), eunf);
        chk({tag, " done"}, int'(done), edone);
        chk({tag, " at_max"}, int'(at_max), (ecnt == 12) ? 1 : 0);
        chk({tag, " at_zero"}, int'(at_zero), (ecnt == 0) ? 1 : 0);
    endtask

    initial begin
        // ld lv en inc dec step mode | cnt ovf unf done
        for (int k = 1; k <= 12; k++) add(0, 0, 1, 1, 0, 1, 0, k, 0, 0, 0);
        add(0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 1, 0, 12, 0, 1, 0);
        // step wrap
        add(1, 10, 1, 0, 0, 5, 0, 10, 0, 0, 0);
        add(0, 0, 1, 1, 0, 5, 0, 2, 1, 0, 0);
        add(0, 0, 1, 0, 1, 3, 0, 12, 0, 1, 0);
        add(0, 0, 1, 1, 0, 15, 0, 11, 1, 0, 0);
        // saturate
        add(1, 11, 1, 0, 0, 4, 1, 11, 0, 0, 0);
        add(0, 0, 1, 1, 0, 4, 1, 12, 1, 0, 0);
        add(0, 0, 1, 1, 0, 4, 1, 12, 1, 0, 0);
        add(1, 2, 1, 0, 0, 4, 1, 2, 0, 0, 0);
        add(0, 0, 1, 0, 1, 4, 1, 0, 0, 1, 0);
        add(1, 1, 1, 0, 0, 2, 1, 1, 0, 0, 0);
        add(0, 0, 1, 0, 1, 2, 1, 0, 0, 1, 0);
        add(0, 0, 1, 0, 1, 2, 1, 0, 0, 1, 0);
        // one-shot
        add(1, 0, 1, 0, 0, 3, 2, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 3, 2, 3, 0, 0, 0);
        add(0, 0, 1, 1, 0, 3, 2, 6, 0, 0, 0);
        add(0, 0, 1, 1, 0, 3, 2, 9, 0, 0, 0);
        add(0, 0, 1, 1, 0, 3, 2, 12, 1, 0, 1);
        add(0, 0, 1, 1, 0, 3, 2, 12, 0, 0, 1);
        add(1, 5, 1, 0, 0, 3, 2, 5, 0, 0, 0);
        // one-shot down, then leave one-shot: done clears and counting resumes
        add(1, 12, 1, 0, 0, 5, 2, 12, 0, 0, 0);
        add(0, 0, 1, 0, 1, 5, 2, 7, 0, 0, 0);
        add(0, 0, 1, 0, 1, 5, 2, 2, 0, 0, 0);
        add(0, 0, 1, 0, 1, 5, 2, 0, 0, 1, 1);
        add(0, 0, 1, 0, 1, 5, 2, 0, 0, 0, 1);
        add(0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0);
        // priority and holds
        add(1, 5, 1, 0, 0, 1, 0, 5, 0, 0, 0);
        add(0, 0, 1, 1, 1, 1, 0, 5, 0, 0, 0);
        add(1, 15, 0, 1, 0, 1, 0, 12, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 12, 0, 0, 0);
        add(0, 0, 0, 1, 0, 1, 0, 12, 0, 0, 0);
        add(0, 0, 1, 1, 0, 1, 3, 0, 1, 0, 0);

        rst = 1'b0; en = 1'b0; inc = 1'b0; dec = 1'b0; load = 1'b0;
        step = 4'd0; mode = 2'd0; load_val = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all("idle", 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            load = vecs[i].ld; load_val = vecs[i].lv; en = vecs[i].en;
            inc = vecs[i].inc; dec = vecs[i].dec; step = vecs[i].step;
            mode = vecs[i].mode;
            @(posedge clk);
            #1;
            chk_all($sformatf("v%0d", i), vecs[i].ecnt, vecs[i].eovf,
                    vecs[i].eunf, vecs[i].edone);
        end

        // async reset between edges while a wrap pulse is showing at cnt = 7
        load = 1'b1; load_val = 4'd10; en = 1'b1; inc = 1'b0; dec = 1'b0;
        step = 4'd10; mode = 2'd0;
        @(posedge clk);
        #1;
        load = 1'b0; inc = 1'b1;
        @(posedge clk);
        #1;
        chk_all("pre_rst", 7, 1, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        step = 4'd1;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst", 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
